// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter/sequencer for a single-port synchronous RAM with
// registered read data. Commands are accepted in IDLE, driven onto the RAM
// port for one ISSUE cycle, and reads spend one RESP cycle collecting data
// before the owner's one-cycle response pulse.
module ram_port_arbiter #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            state;
  logic              rr_ptr;   // requester favoured on contention (round-robin)
  logic              owner;    // requester that issued the command in flight
  logic              cmd_we;   // latched direction of the command in flight
  logic              grant0;
  logic              grant1;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Grant is decided combinationally in IDLE only; held reset blocks any grant.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && state == IDLE) begin
      if (req0_valid && req1_valid) begin
        if (FIXED_PRIO != 0 || !rr_ptr) grant0 = 1'b1;
        else                            grant1 = 1'b1;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Fields of whichever requester wins this cycle.
  assign sel_we    = grant1 ? req1_we    : req0_we;
  assign sel_addr  = grant1 ? req1_addr  : req0_addr;
  assign sel_wdata = grant1 ? req1_wdata : req0_wdata;

  // Sequencer: latch command onto the RAM port, then collect read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      owner      <= 1'b0;
      cmd_we     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            owner    <= grant1;
            cmd_we   <= sel_we;
            ram_we   <= sel_we;
            ram_addr <= sel_addr;
            ram_din  <= sel_wdata;
            // Favour the requester that was not just served.
            if (FIXED_PRIO == 0) rr_ptr <= grant0;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          ram_we <= 1'b0;
          state  <= cmd_we ? IDLE : RESP;
        end
        RESP: begin
          if (owner) begin
            rsp1_rdata <= ram_dout;
            rsp1_valid <= 1'b1;
          end else begin
            rsp0_rdata <= ram_dout;
            rsp0_valid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
